multihart_bus_arbiter: RTL and testbench
========================================

# multihart_bus_arbiter

Parametrised round-robin arbiter that merges `NUM_HARTS` generic-bus requester ports into one downstream generic bus. It sits between the per-hart memory ports of a multi-hart core and the single external generic bus exported by the core top level. Transactions are captured at grant and held stable on the downstream bus until the bus deasserts `busy`. Arbitration is fair: a hart cannot win twice while another hart is waiting.

## Interface
Parameters:
- `NUM_HARTS`, 2: number of requester ports; legal range 1..16.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `req_ren`  in  NUM_HARTS  per-hart read request.
- `req_wen`  in  NUM_HARTS  per-hart write request.
- `req_addr`  in  NUM_HARTS*ADDR_W  per-hart address; hart i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_HARTS*DATA_W  per-hart write data.
- `req_byte_en`  in  NUM_HARTS*DATA_W/8  per-hart byte enables.
- `req_busy`  out  NUM_HARTS  per-hart busy; low only in that hart's completion cycle.
- `req_error`  out  NUM_HARTS  per-hart error; meaningful only in the completion cycle.
- `req_rdata`  out  DATA_W  read data, broadcast to all harts.
- `bus_ren`, `bus_wen`  out  1 each  downstream request.
- `bus_addr`  out  ADDR_W  downstream address.
- `bus_wdata`  out  DATA_W  downstream write data.
- `bus_byte_en`  out  DATA_W/8  downstream byte enables.
- `bus_busy`  in  1  downstream busy.
- `bus_error`  in  1  downstream error.
- `bus_rdata`  in  DATA_W  downstream read data.
- `grant_valid`  out  1  a transaction is in flight.
- `grant_id`  out  $clog2(NUM_HARTS), minimum width 1  index of the hart that owns the transaction in flight.

## Operation
- The FSM has two states, IDLE and GRANT.
- **IDLE:**
  - A hart is requesting when `req_ren[i] | req_wen[i]` is high.
  - If any hart is requesting, the arbiter searches from `rr_ptr` upward, modulo NUM_HARTS, and picks the first requesting hart g.
  - At the clock edge it latches g's addr, wdata and byte_en into the bus registers.
  - It latches `bus_wen = req_wen[g]` and `bus_ren = req_ren[g] & ~req_wen[g]`. Write wins if both are asserted.
  - It sets `grant_id = g` and moves to GRANT.
  - If no hart is requesting, it stays in IDLE.
- **GRANT:**
  - The downstream outputs are driven only from the latched registers. Changes on the `req_*` inputs are ignored, including a granted hart dropping its request.
  - When `bus_busy == 0`, that cycle is the completion cycle:
    - `req_busy[g] = 0`.
    - `req_error[g] = bus_error`.
    - At the edge: FSM goes to IDLE, `bus_ren`/`bus_wen` clear to 0, and `rr_ptr` becomes (g+1) mod NUM_HARTS.
  - While `bus_busy == 1`, the FSM stays in GRANT.
- **Combinational outputs:**
  - `req_busy[i] = ~(state==GRANT & ~bus_busy & grant_id==i)`. Harts that are idle, waiting or not granted all see busy = 1.
  - `req_error[i] = (state==GRANT & ~bus_busy & grant_id==i) & bus_error`.
  - `req_rdata = bus_rdata` in every cycle.
- **Register values:** `rr_ptr` changes only on completion. `grant_id` keeps its last value while in IDLE.
- **NUM_HARTS == 1:** `rr_ptr` and `grant_id` are constant 0. Behaviour is otherwise identical.

## Timing
- **Reset** (nRST low at an edge):
  - state = IDLE.
  - `bus_ren` = `bus_wen` = 0.
  - `bus_addr` = `bus_wdata` = `bus_byte_en` = 0.
  - `rr_ptr` = 0, `grant_id` = 0, `grant_valid` = 0.
  - `req_busy` = all 1, `req_error` = all 0.
- **Reset mid-GRANT:** the downstream transaction is abandoned at the next edge. No completion is reported to the hart, and the downstream slave is reset by the same `nRST`.
- **Latency:**
  - Request seen in IDLE at cycle 0 → `bus_ren`/`bus_wen` high from cycle 1.
  - Downstream zero-wait (`bus_busy` low in cycle 1) → hart sees `req_busy` low in cycle 1.
  - Minimum of 2 cycles per transaction: 1 arbitration cycle plus at least 1 bus cycle.
- **Back-to-back requests:** in the IDLE cycle after a completion, a hart still asserting a request is arbitrated again as a new transaction. Requesters must drop ren/wen in the cycle after their completion.
- **Fairness:** with all harts requesting continuously, grants rotate 0,1,…,N-1,0. The worst-case wait for any hart is NUM_HARTS-1 transactions.
- **Simultaneous events:** a new request arriving in a completion cycle is not arbitrated until the following IDLE cycle.
- **`grant_valid`** equals (state == GRANT).

## Test plan
- **Single read:**
  - Stimulus: hart 1 asserts ren, addr 0x8000_0010; bus_busy held high for 3 cycles, then low with rdata 0xDEADBEEF.
  - Response: bus_ren high cycles 1–4, bus_addr 0x8000_0010; req_busy[1] low only in cycle 4; req_rdata 0xDEADBEEF in cycle 4.
- **Round robin, NUM_HARTS=4:**
  - Stimulus: all harts request continuously; zero-wait bus.
  - Response: grant_id sequence 0,1,2,3,0,1; one completion every 2 cycles.
- **Pointer advance:**
  - Stimulus: after hart 2 completes, harts 0 and 3 request together.
  - Response: hart 3 is granted first, then hart 0.
- **Stable latch on write:**
  - Stimulus: hart 0 writes wdata 0x1234_5678, byte_en 4'b0011; hart 0 changes its inputs while bus_busy is high.
  - Response: bus_wdata and bus_byte_en hold 0x1234_5678 / 4'b0011 until completion.
  - Also: ren and wen asserted together → only bus_wen is high.
- **Error forwarding:**
  - Stimulus: bus_error high in hart 1's completion cycle.
  - Response: req_error[1] = 1 and req_error[0] = 0 in that cycle; both 0 in every other cycle.
- **Reset mid-GRANT:**
  - Stimulus: nRST low for 1 cycle while bus_busy is high.
  - Response: next cycle state IDLE, bus_ren = 0, rr_ptr = 0, all req_busy = 1; no completion pulse ever appears.

Source files
------------

// File: rtl/multihart_bus_arbiter.sv
// Round-robin merge of NUM_HARTS generic-bus requester ports onto one downstream bus.
// The winning request is captured at grant and held on the bus until it completes.
module multihart_bus_arbiter #(
    parameter  int NUM_HARTS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int BE_W      = DATA_W / 8,
    localparam int ID_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_HARTS-1:0]      req_ren,
    input  logic [NUM_HARTS-1:0]      req_wen,
    input  logic [NUM_HARTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_HARTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_HARTS*BE_W-1:0] req_byte_en,
    output logic [NUM_HARTS-1:0]      req_busy,
    output logic [NUM_HARTS-1:0]      req_error,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      bus_ren,
    output logic                      bus_wen,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic [BE_W-1:0]           bus_byte_en,
    input  logic                      bus_busy,
    input  logic                      bus_error,
    input  logic [DATA_W-1:0]         bus_rdata,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       next_ptr;
    logic [NUM_HARTS-1:0]  requesting;
    logic                  found;
    logic [ID_W-1:0]       pick;
    logic                  pick_ren;
    logic                  pick_wen;
    logic [ADDR_W-1:0]     pick_addr;
    logic [DATA_W-1:0]     pick_wdata;
    logic [BE_W-1:0]       pick_be;
    logic                  done;

    assign requesting  = req_ren | req_wen;
    assign done        = (state == GRANT) && !bus_busy;
    assign grant_valid = (state == GRANT);
    assign req_rdata   = bus_rdata;

    // Walk the harts starting at rr_ptr, wrapping once; the first requester wins.
    always_comb begin : arbitrate
        int              idx;
        logic [ID_W-1:0] idx_s;
        idx        = 0;
        idx_s      = '0;
        found      = 1'b0;
        pick       = '0;
        pick_ren   = 1'b0;
        pick_wen   = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        pick_be    = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_HARTS) begin
                idx = idx - NUM_HARTS;
            end
            idx_s = idx[ID_W-1:0];
            if (!found && requesting[idx_s]) begin
                found      = 1'b1;
                pick       = idx_s;
                pick_ren   = req_ren[idx_s];
                pick_wen   = req_wen[idx_s];
                pick_addr  = req_addr[idx*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[idx*DATA_W +: DATA_W];
                pick_be    = req_byte_en[idx*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        next_ptr = grant_id + 1'b1;
        if (int'(grant_id) + 1 >= NUM_HARTS) begin
            next_ptr = '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = GRANT;
            GRANT:   if (!bus_busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Only the granted hart ever sees busy drop, and only in its completion cycle.
    always_comb begin
        req_busy  = '1;
        req_error = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (done && (grant_id == ID_W'(i))) begin
                req_busy[i]  = 1'b0;
                req_error[i] = bus_error;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            bus_ren     <= 1'b0;
            bus_wen     <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_byte_en <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && found) begin
                grant_id    <= pick;
                bus_wen     <= pick_wen;
                bus_ren     <= pick_ren & ~pick_wen;
                bus_addr    <= pick_addr;
                bus_wdata   <= pick_wdata;
                bus_byte_en <= pick_be;
            end else if (done) begin
                bus_ren <= 1'b0;
                bus_wen <= 1'b0;
                rr_ptr  <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_multihart_bus_arbiter.sv
// Randomised and directed bench for multihart_bus_arbiter with a transaction-level model.
module tb_multihart_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            nRST = 1'b0;
    logic [N-1:0]    req_ren = '0;
    logic [N-1:0]    req_wen = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*BW-1:0] req_byte_en = '0;
    logic [N-1:0]    req_busy;
    logic [N-1:0]    req_error;
    logic [DW-1:0]   req_rdata;
    logic            bus_ren;
    logic            bus_wen;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [BW-1:0]   bus_byte_en;
    logic            bus_busy = 1'b0;
    logic            bus_error = 1'b0;
    logic [DW-1:0]   bus_rdata = '0;
    logic            grant_valid;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    multihart_bus_arbiter #(.NUM_HARTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(clk), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byte_en(req_byte_en),
        .req_busy(req_busy), .req_error(req_error), .req_rdata(req_rdata),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
        .bus_busy(bus_busy), .bus_error(bus_error), .bus_rdata(bus_rdata),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one in-flight transaction, a rotating start pointer.
    bit            m_active = 1'b0;
    int            m_gid    = 0;
    int            m_ptr    = 0;
    logic          m_ren    = 1'b0;
    logic          m_wen    = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [BW-1:0] m_be     = '0;

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            int h;
            h = (m_ptr + k) % N;
            if (req_ren[h[1:0]] || req_wen[h[1:0]]) return h;
        end
        return -1;
    endfunction

    initial forever begin
        int g;
        @(posedge clk);
        if (!nRST) begin
            m_active = 1'b0; m_ren = 1'b0; m_wen = 1'b0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_ptr = 0; m_gid = 0;
        end else if (!m_active) begin
            g = m_pick();
            if (g >= 0) begin
                m_active = 1'b1;
                m_gid    = g;
                m_wen    = req_wen[g[1:0]];
                m_ren    = req_ren[g[1:0]] && !req_wen[g[1:0]];
                m_addr   = req_addr[g*AW +: AW];
                m_wdata  = req_wdata[g*DW +: DW];
                m_be     = req_byte_en[g*BW +: BW];
            end
        end else if (!bus_busy) begin
            m_active = 1'b0; m_ren = 1'b0; m_wen = 1'b0;
            m_ptr    = (m_gid + 1) % N;
        end
    end

    initial forever begin
        logic [N-1:0] eb;
        logic [N-1:0] ee;
        @(negedge clk);
        eb = '1;
        ee = '0;
        if (m_active && !bus_busy) begin
            eb[m_gid[1:0]] = 1'b0;
            ee[m_gid[1:0]] = bus_error;
        end
        chk("bus_ren", bus_ren, m_ren);
        chk("bus_wen", bus_wen, m_wen);
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_wdata", bus_wdata, m_wdata);
        chk("bus_byte_en", bus_byte_en, m_be);
        chk("grant_valid", grant_valid, m_active);
        chk("grant_id", grant_id, m_gid[1:0]);
        chk("req_busy", req_busy, eb);
        chk("req_error", req_error, ee);
        chk("req_rdata", req_rdata, bus_rdata);
    end

    // Requesters hold ren/wen until their completion cycle, then drop.
    logic [N-1:0] want_ren = '0;
    logic [N-1:0] want_wen = '0;
    int glog[$];
    int clog[$];

    task automatic set_hart(input int h, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be);
        req_addr[h*AW +: AW]    = a;
        req_wdata[h*DW +: DW]   = d;
        req_byte_en[h*BW +: BW] = be;
    endtask

    task automatic tick_a();
        req_ren = want_ren;
        req_wen = want_wen;
        @(negedge clk);
        if (nRST && m_active && !bus_busy) begin
            glog.push_back(int'(grant_id));
            clog.push_back(cyc);
            want_ren[m_gid[1:0]] = 1'b0;
            want_wen[m_gid[1:0]] = 1'b0;
        end
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    initial begin
        int exp_rr[6];
        exp_rr = '{0, 1, 2, 3, 0, 1};

        // reset
        nRST = 1'b0;
        tick_a();
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_bus_ren", bus_ren, 1'b0);
        chk("rst_bus_wen", bus_wen, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_req_busy", req_busy, 4'hF);
        chk("rst_req_error", req_error, 4'h0);
        chk("rst_grant_id", grant_id, 2'd0);
        tick_b();
        tick();
        nRST = 1'b1;
        tick();

        // round robin, zero-wait bus
        glog.delete(); clog.delete();
        bus_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            want_ren = '1;
            tick();
        end
        want_ren = '0;
        chk("rr_count", glog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) chk("rr_order", glog[i], exp_rr[i]);
            if (i > 0 && i < clog.size()) chk("rr_spacing", clog[i] - clog[i-1], 2);
        end
        tick();

        // single read by hart 1 with three wait cycles
        set_hart(1, 32'h8000_0010, 32'h0, 4'hF);
        want_ren[1] = 1'b1;
        bus_busy = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick_a();
            chk("rd_bus_ren", bus_ren, 1'b1);
            chk("rd_bus_addr", bus_addr, 32'h8000_0010);
            chk("rd_req_busy_wait", req_busy, 4'hF);
            tick_b();
        end
        bus_busy = 1'b0;
        bus_rdata = 32'hDEAD_BEEF;
        tick_a();
        chk("rd_bus_ren_last", bus_ren, 1'b1);
        chk("rd_req_busy_done", req_busy, 4'b1101);
        chk("rd_rdata", req_rdata, 32'hDEAD_BEEF);
        tick_b();
        bus_busy = 1'b1;
        tick_a();
        chk("rd_bus_ren_after", bus_ren, 1'b0);
        chk("rd_idle", grant_valid, 1'b0);
        tick_b();

        // pointer advance after hart 2
        glog.delete();
        bus_busy = 1'b0;
        want_ren[2] = 1'b1;
        tick(); tick();
        want_ren[0] = 1'b1;
        want_wen[3] = 1'b1;
        repeat (4) tick();
        chk("ptr_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("ptr_first", glog[0], 2);
            chk("ptr_second", glog[1], 3);
            chk("ptr_third", glog[2], 0);
        end

        // stable latch on write, ren+wen together
        set_hart(0, 32'h0000_0040, 32'h1234_5678, 4'b0011);
        want_ren[0] = 1'b1;
        want_wen[0] = 1'b1;
        bus_busy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_hart(0, $urandom, $urandom, 4'b1100);
            tick_a();
            chk("wr_wdata", bus_wdata, 32'h1234_5678);
            chk("wr_be", bus_byte_en, 4'b0011);
            chk("wr_wen", bus_wen, 1'b1);
            chk("wr_ren", bus_ren, 1'b0);
            chk("wr_addr", bus_addr, 32'h40);
            tick_b();
        end
        bus_busy = 1'b0;
        tick_a();
        chk("wr_wdata_done", bus_wdata, 32'h1234_5678);
        chk("wr_busy_done", req_busy, 4'b1110);
        tick_b();

        // error forwarding for hart 1
        want_ren[1] = 1'b1;
        bus_busy = 1'b1;
        bus_error = 1'b1;
        tick_a();
        chk("err_idle", req_error, 4'h0);
        tick_b();
        bus_busy = 1'b0;
        tick_a();
        chk("err_done", req_error, 4'b0010);
        chk("err_busy", req_busy, 4'b1101);
        tick_b();
        tick_a();
        chk("err_after", req_error, 4'h0);
        tick_b();
        bus_error = 1'b0;

        // reset while hart 2 is granted and the bus is busy
        want_ren[2] = 1'b1;
        bus_busy = 1'b1;
        tick();
        tick_a();
        chk("rstg_valid", grant_valid, 1'b1);
        chk("rstg_id", grant_id, 2'd2);
        tick_b();
        nRST = 1'b0;
        tick();
        want_ren = '0; want_wen = '0;
        nRST = 1'b1;
        tick_a();
        chk("rstg_after_valid", grant_valid, 1'b0);
        chk("rstg_after_ren", bus_ren, 1'b0);
        chk("rstg_after_busy", req_busy, 4'hF);
        tick_b();
        glog.delete();
        bus_busy = 1'b0;
        want_ren[0] = 1'b1;
        want_ren[3] = 1'b1;
        repeat (4) tick();
        chk("rstg_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("rstg_first", glog[0], 0);
            chk("rstg_second", glog[1], 3);
        end

        // randomised traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            for (int h = 0; h < N; h++) begin
                set_hart(h, $urandom, $urandom, 4'($urandom));
                if (!want_ren[h[1:0]] && !want_wen[h[1:0]] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0: want_ren[h[1:0]] = 1'b1;
                        1: want_wen[h[1:0]] = 1'b1;
                        default: begin
                            want_ren[h[1:0]] = 1'b1;
                            want_wen[h[1:0]] = 1'b1;
                        end
                    endcase
                end
            end
            bus_busy  = ($urandom_range(0, 2) == 0);
            bus_error = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            nRST      = ($urandom_range(0, 99) != 0);
            tick();
            if (!nRST) begin
                want_ren = '0;
                want_wen = '0;
            end
        end
        nRST = 1'b1;
        want_ren = '0;
        want_wen = '0;
        bus_busy = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
